// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length and parity sense.
// Used by ps2_tx, ps2_rx and the rxtx wrapper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int   FRAME_LEN  = 11;
  localparam logic PARITY_ODD = 1'b1;

  function automatic logic parity_bit(input logic [7:0] d);
    return PARITY_ODD ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher: the filtered level only flips after FILTER_LEN identical
// consecutive samples; fall_edge marks the cycle the filtered level drops.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2c_in,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  f_ps2c_q, f_ps2c_d;

  always_comb begin
    filter_d = {ps2c_in, filter_q[FILTER_LEN-1:1]};
    f_ps2c_d = f_ps2c_q;
    if (&filter_d)       f_ps2c_d = 1'b1;
    else if (~|filter_d) f_ps2c_d = 1'b0;
  end

  assign fall_edge = f_ps2c_q & ~f_ps2c_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filter_q <= '0;
      f_ps2c_q <= 1'b0;
    end else begin
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then clocks one byte plus odd
// parity out on the device's clock. Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int CW = $clog2(RTS_CYCLES + 1);
  localparam logic [CW-1:0] RTS_LOAD = CW'(RTS_CYCLES - 1);
  // n counts the remaining shifts after the first data/parity bit
  localparam logic [3:0] N_LOAD = 4'(FRAME_LEN - 3);

  if (RTS_CYCLES < 2 || FILTER_LEN < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ps2_tx: RTS_CYCLES, FILTER_LEN and TIMEOUT_CYCLES must all be >= 2");
  end

  ps2_state_e     state_q, state_d;
  logic [8:0]     b_q, b_d;
  logic [CW-1:0]  c_q, c_d;
  logic [3:0]     n_q, n_d;
  logic           ps2c_en_q, ps2c_en_d;
  logic           ps2d_en_q, ps2d_en_d;
  logic           done_q, done_d;
  logic           fall_edge;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2c_in   (ps2c),
    .fall_edge (fall_edge)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    c_d     = c_q;
    n_d     = n_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (wr_ps2) begin
        b_d     = {parity_bit(din), din};
        c_d     = RTS_LOAD;
        state_d = ST_RTS;
      end
      ST_RTS: begin
        if (c_q == '0) state_d = ST_START;
        else           c_d     = c_q - CW'(1);
      end
      ST_START: if (fall_edge) begin
        n_d     = N_LOAD;
        state_d = ST_DATA;
      end
      ST_DATA: if (fall_edge) begin
        b_d = {1'b0, b_q[8:1]};
        if (n_q == '0) state_d = ST_STOP;
        else           n_d     = n_q - 4'd1;
      end
      ST_STOP: if (fall_edge) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    err_d = 1'b0;
    wd_d  = wd_q;
    if (state_q == ST_IDLE) wd_d = '0;
    else if (state_q != ST_RTS) wd_d = fall_edge ? '0 : wd_q + WW'(1);
    // Abort wins over any edge arriving in the same cycle
    if (state_q inside {ST_START, ST_DATA, ST_STOP} && wd_q == WW'(TIMEOUT_CYCLES)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
      wd_d    = '0;
    end
`endif

    // Pad enables follow the next state so the pins change only on a clock edge
    ps2c_en_d = (state_d == ST_RTS);
    ps2d_en_d = (state_d == ST_START) || ((state_d == ST_DATA) && !b_d[0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      b_q       <= '0;
      c_q       <= '0;
      n_q       <= '0;
      ps2c_en_q <= 1'b0;
      ps2d_en_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      c_q       <= c_d;
      n_q       <= n_d;
      ps2c_en_q <= ps2c_en_d;
      ps2d_en_q <= ps2d_en_d;
      done_q    <= done_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

  assign ps2c         = ps2c_en_q ? 1'b0 : 1'bz;
  assign ps2d         = ps2d_en_q ? 1'b0 : 1'bz;
  assign tx_idle      = (state_q == ST_IDLE);
  assign tx_done_tick = done_q;
`ifdef PS2_TX_TIMEOUT_EN
  assign tx_err       = err_q;
`else
  assign tx_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: models a PS/2 device with pull-ups that clocks the
// frame in and ACKs; expected frames come from the byte with plain arithmetic.
module tb_ps2_tx;

  localparam int RTS  = 5000;
  localparam int FLEN = 8;
  localparam int TO   = 3000;
  localparam int H    = 40;   // device clock half-period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = '0;
  logic       tx_idle, tx_done_tick, tx_err;
  logic       dev_c_low = 1'b0, dev_d_low = 1'b0;
  wire        ps2c, ps2d;

  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0;

  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);

  ps2_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .wr_ps2(wr_ps2), .din(din),
    .ps2c(ps2c), .ps2d(ps2d),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done_tick) done_cnt++;
    if (tx_err)       err_cnt++;
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start bit, data LSB first, odd parity, stop: bit k is the k-th bit on the wire
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2) == 0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic pulse_wr(input logic [7:0] d);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Device side: measures RTS, then clocks 11 bits, sampling ps2d late in each high phase.
  task automatic dev_frame(input int glitch_k, input int wr_k, input int rst_k,
                           output logic [10:0] bits, output int rts_len, output bit ok);
    int w;
    bits = '0; rts_len = 0; ok = 1'b0;
    w = 0;
    while (ps2c !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    if (ps2c !== 1'b0) return;
    while (ps2c === 1'b0 && rts_len < RTS + 100) begin @(negedge clk); rts_len++; end
    chk("start_bit_driven", ps2d, 1'b0);
    repeat (H/2) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      if (k == glitch_k) begin
        repeat (H/4) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_c_low = 1'b0;
      end
      if (k == wr_k) pulse_wr(8'h3C);
      repeat (H/2) @(negedge clk);
      if (k == rst_k) begin
        chk("pre_rst_d_low", ps2d, 1'b0);
        chk("pre_rst_busy", tx_idle, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_ps2c_rel", ps2c, 1'b1);
        chk("rst_ps2d_rel", ps2d, 1'b1);
        chk("rst_idle", tx_idle, 1'b1);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        ok = 1'b1;
        return;
      end
      bits[k] = ps2d;
      dev_c_low = 1'b1;
      if (k == 10) dev_d_low = 1'b1;  // ACK
      repeat (H) @(negedge clk);
      dev_c_low = 1'b0;
      dev_d_low = 1'b0;
      repeat (H/2) @(negedge clk);
    end
    ok = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d,
                           input int glitch_k, input int wr_k);
    logic [10:0] bits;
    int rts_len, d0, w, lows;
    bit ok;
    d0 = done_cnt;
    pulse_wr(d);
    chk({tag, "_rts_lat"}, ps2c, 1'b0);
    dev_frame(glitch_k, wr_k, -1, bits, rts_len, ok);
    chk({tag, "_dev_ok"}, ok, 1'b1);
    chk({tag, "_rts_len"}, rts_len, RTS);
    chk({tag, "_bits"}, bits, exp_frame(d));
    w = 0;
    while (done_cnt == d0 && w < 200) begin @(negedge clk); w++; end
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ps2c === 1'b0) lows++;
    end
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_idle"}, tx_idle, 1'b1);
    chk({tag, "_no_new_rts"}, lows, 0);
    chk({tag, "_d_rel"}, ps2d, 1'b1);
  endtask

  initial begin
    int d0;
    logic [10:0] bits;
    int rts_len;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_idle", tx_idle, 1'b1);
    chk("rst_done", tx_done_tick, 1'b0);
    chk("rst_err", tx_err, 1'b0);
    chk("rst_ps2c", ps2c, 1'b1);
    chk("rst_ps2d", ps2d, 1'b1);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    run_frame("f4", 8'hF4, -1, -1);
    run_frame("zero", 8'h00, -1, -1);
    run_frame("ones", 8'hFF, -1, -1);
    run_frame("glitch", 8'($urandom_range(0, 255)), 3, -1);
    run_frame("wr_busy", 8'hA5, -1, 4);
    for (int i = 0; i < 3; i++) run_frame("rand", 8'($urandom), -1, -1);

    // Reset while the host is driving a 0 data bit
    d0 = done_cnt;
    pulse_wr(8'h00);
    dev_frame(-1, -1, 5, bits, rts_len, ok);
    chk("rst_mid_ok", ok, 1'b1);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    run_frame("post_rst", 8'($urandom), -1, -1);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int e0, w;
      d0 = done_cnt;
      e0 = err_cnt;
      pulse_wr(8'h5A);
      w = 0;
      while (ps2c === 1'b0 && w < RTS + 100) begin @(negedge clk); w++; end
      w = 0;
      while (err_cnt == e0 && w < TO + 500) begin @(negedge clk); w++; end
      chk("wd_err_once", err_cnt - e0, 1);
      chk("wd_latency_ok", (w >= TO && w <= TO + 5), 1'b1);
      chk("wd_no_done", done_cnt - d0, 0);
      repeat (3) @(negedge clk);
      chk("wd_idle", tx_idle, 1'b1);
      chk("wd_d_rel", ps2d, 1'b1);
      chk("wd_c_rel", ps2c, 1'b1);
    end
`else
    chk("no_err_pulses", err_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
